// File: rtl/wallace_ctrl.sv
// -----------------------------------------------------------------------------
// wallace_ctrl
//   Operand-load and run-control stage in front of the Wallace-tree multiplier.
//   Synchronises the Run and ClearA_LoadB buttons, loads the switch value into
//   the multiplicand (MUD) or multiplier (MUR) register, waits a fixed tree
//   latency, then captures the product into a held result register and pulses
//   done for one cycle.
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset         in   asynchronous active-low reset
//   Run           in   start button, asynchronous to Clk
//   ClearA_LoadB  in   clear-result / load-multiplicand button, asynchronous
//   SW            in   [WIDTH]    switch operand
//   MUR           out  [WIDTH]    multiplier register to the tree
//   MUD           out  [WIDTH]    multiplicand register to the tree
//   prod_i        in   [2*WIDTH]  product returned by the tree
//   result        out  [2*WIDTH]  captured product, held
//   busy          out  high in LOAD, WAIT and CAPTURE
//   done          out  one-cycle pulse after result updates
// -----------------------------------------------------------------------------
module wallace_ctrl #(
  parameter int WIDTH        = 16,
  parameter int TREE_LATENCY = 2,   // 1..15
  parameter int SYNC_STAGES  = 2    // >= 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 ClearA_LoadB,
  input  logic [WIDTH-1:0]     SW,
  output logic [WIDTH-1:0]     MUR,
  output logic [WIDTH-1:0]     MUD,
  input  logic [2*WIDTH-1:0]   prod_i,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam int              CW       = 4;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TREE_LATENCY - 1);

  // ---------------------------------------------------------------------------
  // Button synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] run_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic [SYNC_STAGES-1:0] prime;     // fills with 1s as real samples reach run_s
  logic                   run_s;
  logic                   clr_s;
  logic                   run_s_d;
  logic                   armed;
  logic                   primed;
  logic                   run_rise;

  assign run_s  = run_sync[SYNC_STAGES-1];
  assign clr_s  = clr_sync[SYNC_STAGES-1];
  assign primed = prime[SYNC_STAGES-1];

  // A rise only counts once Run has been seen low after reset; otherwise a
  // button already held through reset release would look like a fresh press
  // when the synchroniser fills up from its cleared value.
  assign run_rise = armed & run_s & ~run_s_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the shift chain work.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_sync <= '0;
      clr_sync <= '0;
      prime    <= '0;
      run_s_d  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      run_sync <= {run_sync[SYNC_STAGES-2:0], Run};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], ClearA_LoadB};
      prime    <= {prime[SYNC_STAGES-2:0], 1'b1};
      run_s_d  <= run_s;
      armed    <= armed | (primed & ~run_s);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic           load_mud;
  logic           clr_result;
  logic           load_mur;
  logic           cnt_inc;
  logic           capture;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_mud   = 1'b0;
    clr_result = 1'b0;
    load_mur   = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_s) begin
          // Clear wins over a simultaneous Run press; that press is dropped.
          load_mud   = 1'b1;
          clr_result = 1'b1;
        end else if (run_rise) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        load_mur   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        cnt_inc = 1'b1;
        if (cnt == CNT_LAST) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture    = 1'b1;
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!run_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      MUR    <= '0;
      MUD    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= capture;
      if (load_mur)      cnt <= '0;
      else if (cnt_inc)  cnt <= cnt + 1'b1;
      if (load_mur)      MUR <= SW;
      if (load_mud)      MUD <= SW;
      if (clr_result)    result <= '0;
      else if (capture)  result <= prod_i;
    end
  end

  assign busy = (state == S_LOAD) || (state == S_WAIT) || (state == S_CAPTURE);

endmodule

// File: tb/tb_wallace_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wallace_ctrl
//   Self-checking bench for wallace_ctrl. The multiplier tree is modelled as a
//   TREE_LATENCY-deep pipeline of MUR*MUD. Expected register contents come from
//   a transaction-level model: a clear sets MUD and zeroes result, a run loads
//   MUR and produces MUR*MUD after TREE_LATENCY+2 busy-relative edges.
// -----------------------------------------------------------------------------
module tb_wallace_ctrl;

  localparam int W  = 16;
  localparam int TL = 2;
  localparam int SS = 2;

  logic            Clk;
  logic            Reset;
  logic            Run;
  logic            ClearA_LoadB;
  logic [W-1:0]    SW;
  logic [W-1:0]    MUR;
  logic [W-1:0]    MUD;
  logic [2*W-1:0]  prod_i;
  logic [2*W-1:0]  result;
  logic            busy;
  logic            done;

  int errors = 0;
  int checks = 0;

  // Transaction-level expectations
  logic [W-1:0]    mur_m;
  logic [W-1:0]    mud_m;
  logic [2*W-1:0]  res_m;

  wallace_ctrl #(.WIDTH(W), .TREE_LATENCY(TL), .SYNC_STAGES(SS)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .SW           (SW),
    .MUR          (MUR),
    .MUD          (MUD),
    .prod_i       (prod_i),
    .result       (result),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Tree model: product of the registered operands, TL cycles late.
  logic [2*W-1:0] pipe [TL];
  always @(posedge Clk) begin
    pipe[0] <= {{W{1'b0}}, MUR} * {{W{1'b0}}, MUD};
    for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
  end
  assign prod_i = pipe[TL-1];

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press_clear(input logic [W-1:0] sw);
    SW = sw;
    ClearA_LoadB = 1'b1;
    cyc(SS + 2);
    ClearA_LoadB = 1'b0;
    cyc(SS + 2);
    mud_m = sw;
    res_m = '0;
  endtask

  // One run: press Run with switch value sw, follow the busy window, keep Run
  // held for hold cycles after done, then release. Optionally press
  // ClearA_LoadB (with SW=0x1234) while the operation is in WAIT.
  task automatic run_op(input logic [W-1:0] sw, input int hold, input bit clr_in_wait);
    int              n;
    int              nb;
    int              extra_done;
    bit              early_bad;
    bit              res_moved;
    logic [2*W-1:0]  exp_res;
    logic [2*W-1:0]  old_res;
    old_res = res_m;
    exp_res = {{W{1'b0}}, sw} * {{W{1'b0}}, mud_m};
    SW  = sw;
    Run = 1'b1;
    n = 0;
    while (!busy && n < 30) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL run_start_timeout: busy=%b after %0d cycles, required 1", busy, n);
      Run = 1'b0;
      cyc(SS + 3);
      return;
    end
    // LOAD cycle: MUR not yet loaded
    checks++;
    if (MUR !== mur_m) begin
      errors++;
      $display("FAIL mur_before_load: MUR=%h required %h", MUR, mur_m);
    end
    nb = 0;
    early_bad = 0;
    while (busy && nb < 40) begin
      nb++;
      if (done !== 1'b0 || result !== old_res) early_bad = 1;
      if (nb == 2) begin
        checks++;
        if (MUR !== sw) begin
          errors++;
          $display("FAIL mur_at_edge1: MUR=%h required %h", MUR, sw);
        end
        if (clr_in_wait) begin
          ClearA_LoadB = 1'b1;
          SW = 16'h1234;
        end
      end
      @(negedge Clk);
    end
    checks++;
    if (nb != TL + 2) begin
      errors++;
      $display("FAIL busy_length: busy cycles=%0d required %0d", nb, TL + 2);
    end
    checks++;
    if (early_bad) begin
      errors++;
      $display("FAIL early_capture: done/result changed while busy, required stable (old result %h)", old_res);
    end
    // First HOLD cycle
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done=%b required 1", done);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL result: result=%h required %h (sw=%h mud=%h)", result, exp_res, sw, mud_m);
    end
    mur_m = sw;
    res_m = exp_res;
    @(negedge Clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b required 0 on second HOLD cycle", done);
    end
    if (clr_in_wait) ClearA_LoadB = 1'b0;
    extra_done = 0;
    res_moved  = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      if (done) extra_done++;
      if (busy || result !== res_m) res_moved = 1;
    end
    checks++;
    if (extra_done != 0 || res_moved) begin
      errors++;
      $display("FAIL hold_retrigger: extra done=%0d recapture=%0b required 0/0", extra_done, res_moved);
    end
    Run = 1'b0;
    cyc(SS + 3);
    checks++;
    if (busy !== 1'b0 || MUD !== mud_m || MUR !== mur_m) begin
      errors++;
      $display("FAIL after_run: busy=%b MUD=%h MUR=%h required 0 %h %h", busy, MUD, MUR, mud_m, mur_m);
    end
  endtask

  task automatic test_reset;
    bit started;
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Run          = 1'($urandom);
      ClearA_LoadB = 1'($urandom);
      SW           = W'($urandom);
      @(negedge Clk);
      checks++;
      if ({MUR, MUD, result, busy, done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: MUR=%h MUD=%h result=%h busy=%b done=%b required all 0",
                 MUR, MUD, result, busy, done);
      end
    end
    Run = 1'b1;
    ClearA_LoadB = 1'b0;
    SW = 16'h00AA;
    Reset = 1'b1;
    started = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (busy || done) started = 1;
    end
    checks++;
    if (started) begin
      errors++;
      $display("FAIL run_held_through_reset: operation started=%0b required 0", started);
    end
    Run = 1'b0;
    cyc(SS + 3);
    mur_m = '0;
    mud_m = '0;
    res_m = '0;
  endtask

  task automatic test_basic;
    press_clear(16'h0101);
    checks++;
    if (MUD !== 16'h0101 || result !== '0) begin
      errors++;
      $display("FAIL clear_load: MUD=%h result=%h required 0101 00000000", MUD, result);
    end
    run_op(16'h0101, 3, 0);
    checks++;
    if (result !== 32'h00010201) begin
      errors++;
      $display("FAIL basic_product: result=%h required 00010201", result);
    end
  endtask

  task automatic test_max_and_reuse;
    press_clear(16'hFFFF);
    run_op(16'hFFFF, 3, 0);
    checks++;
    if (result !== 32'hFFFE0001) begin
      errors++;
      $display("FAIL max_product: result=%h required fffe0001", result);
    end
    run_op(16'h0000, 3, 0);
    checks++;
    if (result !== 32'h0 || MUD !== 16'hFFFF) begin
      errors++;
      $display("FAIL reuse_mud: result=%h MUD=%h required 00000000 ffff", result, MUD);
    end
  endtask

  task automatic test_hold_and_clear_in_wait;
    press_clear(16'h0013);
    run_op(16'h0021, 50, 0);
    run_op(16'h0105, 10, 1);
    checks++;
    if (MUD !== 16'h0013) begin
      errors++;
      $display("FAIL clear_in_wait: MUD=%h required 0013", MUD);
    end
  endtask

  task automatic test_same_cycle;
    bit started;
    started = 0;
    SW = 16'h0003;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (busy || done) started = 1;
    end
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (busy || done) started = 1;
    end
    mud_m = 16'h0003;
    res_m = '0;
    checks++;
    if (started || MUD !== mud_m || result !== res_m) begin
      errors++;
      $display("FAIL clear_beats_run: started=%0b MUD=%h result=%h required 0 0003 00000000",
               started, MUD, result);
    end
  endtask

  task automatic test_reset_mid_wait;
    int n;
    bit started;
    press_clear(16'h0002);
    SW  = 16'h00FF;
    Run = 1'b1;
    n = 0;
    while (!busy && n < 30) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({MUR, MUD, result, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: MUR=%h MUD=%h result=%h busy=%b done=%b required all 0",
               MUR, MUD, result, busy, done);
    end
    @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    started = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (busy || done || result !== '0) started = 1;
    end
    checks++;
    if (started) begin
      errors++;
      $display("FAIL after_abort: activity=%0b required 0", started);
    end
    mur_m = '0;
    mud_m = '0;
    res_m = '0;
    press_clear(16'h0002);
    run_op(16'h00FF, 3, 0);
    checks++;
    if (result !== 32'h000001FE) begin
      errors++;
      $display("FAIL fresh_after_reset: result=%h required 000001fe", result);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        press_clear(W'($urandom));
        checks++;
        if (MUD !== mud_m || result !== '0) begin
          errors++;
          $display("FAIL random_clear: MUD=%h result=%h required %h 00000000", MUD, result, mud_m);
        end
      end
      run_op(W'($urandom), $urandom_range(SS + 2, 8), 0);
    end
  endtask

  initial begin
    Reset = 1'b0;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    SW = '0;
    mur_m = '0;
    mud_m = '0;
    res_m = '0;
    cyc(2);
    test_reset();
    test_basic();
    test_max_and_reuse();
    test_hold_and_clear_in_wait();
    test_same_cycle();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
